// File: rtl/dl_row_memory.sv
// Row-organised 64-bit data memory feeding the data-load controller.
// Multi-cycle read/write access with registered row output and lane-masked writes.
module dl_row_memory #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEMREAD,
  input  logic              MEMWRITE,
  input  logic [15:0]       MEMADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [3:0]        WLANE,
  output logic [DATA_W-1:0] DATA,
  output logic              DVALID,
  output logic              WACK,
  output logic              BUSY
);

  localparam int LANE_W = 16;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  wlane_q;
  logic [3:0]        cnt;
  logic              cnt_done;

  logic latch_addr;
  logic latch_wr;
  logic rd_done;
  logic wr_done;

  // Rows wrap modulo depth; upper address bits are intentionally dropped.
  assign addr_in  = MEMADDR[ADDR_W-1:0];
  assign cnt_done = (cnt == CNT_LAST);

  generate
    if (ADDR_W < 16) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^MEMADDR[15:ADDR_W];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (MEMWRITE) begin
          state_next = WRITE;
        end else if (MEMREAD) begin
          state_next = READ;
        end
      end
      READ: begin
        if (cnt_done) begin
          state_next = HOLD;
        end
      end
      WRITE: begin
        if (cnt_done) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (!MEMREAD) begin
          state_next = IDLE;
        end else if (addr_in != addr_q) begin
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_addr = 1'b0;
    latch_wr   = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    unique case (state)
      IDLE: begin
        latch_addr = MEMWRITE | MEMREAD;
        latch_wr   = MEMWRITE;
      end
      READ:  rd_done = cnt_done;
      WRITE: wr_done = cnt_done;
      HOLD:  latch_addr = MEMREAD && (addr_in != addr_q);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA    <= '0;
      DVALID  <= 1'b0;
      WACK    <= 1'b0;
      BUSY    <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wlane_q <= '0;
    end else begin
      DVALID <= rd_done;
      WACK   <= wr_done;
      if (latch_addr) begin
        addr_q <= addr_in;
        BUSY   <= 1'b1;
        cnt    <= '0;
      end else if (state == READ || state == WRITE) begin
        cnt <= cnt + 4'd1;
      end
      if (latch_wr) begin
        wdata_q <= WDATA;
        wlane_q <= WLANE;
      end
      if (rd_done || wr_done) begin
        BUSY <= 1'b0;
      end
      if (rd_done) begin
        DATA <= mem[addr_q];
      end
    end
  end

  // Array is never reset; a reset landing on the commit edge drops the write.
  always_ff @(posedge CLK) begin
    if (!RST && wr_done) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wlane_q[i]) begin
          mem[addr_q][i*LANE_W +: LANE_W] <= wdata_q[i*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_dl_row_memory.sv
// Directed self-checking bench for dl_row_memory (ADDR_W=8, LAT=2).
module tb_dl_row_memory;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [15:0] memaddr;
  logic [63:0] wdata;
  logic [3:0]  wlane;
  logic [63:0] data;
  logic        dvalid;
  logic        wack;
  logic        busy;

  int unsigned total;
  int unsigned bad;
  logic [63:0] held;

  dl_row_memory #(
    .ADDR_W(8),
    .LAT   (LAT),
    .DATA_W(64)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .MEMREAD (memread),
    .MEMWRITE(memwrite),
    .MEMADDR (memaddr),
    .WDATA   (wdata),
    .WLANE   (wlane),
    .DATA    (data),
    .DVALID  (dvalid),
    .WACK    (wack),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [3:0] l);
    memaddr  = a;
    wdata    = d;
    wlane    = l;
    memwrite = 1'b1;
    tick();
    check("wr_busy", busy, 1);
    check("wr_wack_e0", wack, 0);
    memwrite = 1'b0;
    wdata    = ~d;
    wlane    = ~l;
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("wr_wack_early", wack, 0);
    end
    tick();
    check("wr_wack", wack, 1);
    check("wr_busy_clr", busy, 0);
    check("wr_data_kept", data, held);
    tick();
    check("wr_wack_pulse", wack, 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [63:0] exp, input int hold);
    memaddr = a;
    memread = 1'b1;
    tick();
    check("rd_busy", busy, 1);
    check("rd_dvalid_e0", dvalid, 0);
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("rd_dvalid_early", dvalid, 0);
    end
    tick();
    check("rd_dvalid", dvalid, 1);
    check("rd_data", data, exp);
    check("rd_busy_clr", busy, 0);
    held = exp;
    for (int k = 0; k < hold; k++) begin
      tick();
      check("rd_hold_dvalid", dvalid, 0);
      check("rd_hold_data", data, exp);
    end
    memread = 1'b0;
    tick();
    check("rd_idle_busy", busy, 0);
    check("rd_idle_dvalid", dvalid, 0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    held     = '0;
    rst      = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    memaddr  = '0;
    wdata    = '0;
    wlane    = '0;
    tick();
    tick();
    check("rst_data", data, 64'h0);
    check("rst_dvalid", dvalid, 0);
    check("rst_wack", wack, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    do_write(16'd0, 64'h0123_4567_89AB_CDEF, 4'hF);
    do_write(16'd6, 64'h6666_6666_0000_6666, 4'hF);

    // Reset held with a pending read; the read is sampled after release.
    rst     = 1'b1;
    memread = 1'b1;
    memaddr = 16'd0;
    tick();
    check("rstrd_busy", busy, 0);
    check("rstrd_dvalid", dvalid, 0);
    check("rstrd_data", data, 64'h0);
    held = '0;
    rst  = 1'b0;
    tick();
    check("rstrd_sampled", busy, 1);
    tick();
    check("rstrd_dvalid_early", dvalid, 0);
    tick();
    check("rstrd_dvalid", dvalid, 1);
    check("rstrd_row0", data, 64'h0123_4567_89AB_CDEF);
    held    = 64'h0123_4567_89AB_CDEF;
    memread = 1'b0;
    tick();

    do_write(16'd5, 64'h1111_2222_3333_4444, 4'hF);
    do_read(16'd5, 64'h1111_2222_3333_4444, 2);

    do_write(16'd5, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101);
    do_read(16'd5, 64'h1111_BBBB_3333_DDDD, 1);

    // Simultaneous write and read on row 7: write first.
    memaddr  = 16'd7;
    wdata    = 64'h7777_8888_9999_AAAA;
    wlane    = 4'hF;
    memwrite = 1'b1;
    memread  = 1'b1;
    tick();
    check("rw_busy", busy, 1);
    memwrite = 1'b0;
    tick();
    check("rw_wack_early", wack, 0);
    tick();
    check("rw_wack", wack, 1);
    check("rw_no_dvalid", dvalid, 0);
    tick();
    check("rw_rd_sampled", busy, 1);
    check("rw_wack_pulse", wack, 0);
    tick();
    check("rw_dvalid_early", dvalid, 0);
    tick();
    check("rw_dvalid", dvalid, 1);
    check("rw_data", data, 64'h7777_8888_9999_AAAA);
    held = 64'h7777_8888_9999_AAAA;

    // HOLD: same address, ignored write, address changes, wrap.
    tick();
    check("hold_same_dvalid", dvalid, 0);
    check("hold_same_busy", busy, 0);
    memwrite = 1'b1;
    wdata    = 64'h0;
    wlane    = 4'hF;
    tick();
    check("hold_wr_wack", wack, 0);
    check("hold_wr_busy", busy, 0);
    memwrite = 1'b0;
    memaddr  = 16'd5;
    tick();
    check("hold_chg_busy", busy, 1);
    memaddr = 16'd6;
    tick();
    check("hold_chg_dvalid_early", dvalid, 0);
    tick();
    check("hold_chg_dvalid", dvalid, 1);
    check("hold_chg_row5", data, 64'h1111_BBBB_3333_DDDD);
    tick();
    check("hold_row6_busy", busy, 1);
    tick();
    check("hold_row6_early", dvalid, 0);
    tick();
    check("hold_row6_dvalid", dvalid, 1);
    check("hold_row6_data", data, 64'h6666_6666_0000_6666);
    memaddr = 16'h0105;
    tick();
    check("wrap_busy", busy, 1);
    tick();
    tick();
    check("wrap_dvalid", dvalid, 1);
    check("wrap_data", data, 64'h1111_BBBB_3333_DDDD);
    held    = 64'h1111_BBBB_3333_DDDD;
    memread = 1'b0;
    tick();
    check("wrap_idle", busy, 0);

    do_write(16'd7, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
    do_read(16'd7, 64'h7777_8888_9999_AAAA, 0);

    // Reset one cycle into a write aborts it.
    do_write(16'd9, 64'h9999_0000_9999_0000, 4'hF);
    do_read(16'd9, 64'h9999_0000_9999_0000, 0);
    memaddr  = 16'd9;
    wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
    wlane    = 4'hF;
    memwrite = 1'b1;
    tick();
    check("abort_busy", busy, 1);
    memwrite = 1'b0;
    rst      = 1'b1;
    tick();
    check("abort_wack", wack, 0);
    check("abort_busy_clr", busy, 0);
    check("abort_data", data, 64'h0);
    held = '0;
    rst  = 1'b0;
    tick();
    check("abort_no_wack", wack, 0);
    tick();
    check("abort_no_wack2", wack, 0);
    do_read(16'd9, 64'h9999_0000_9999_0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
